// File: rtl/distributor14_if.sv
// distributor14_if: handshake and channel bus for the 1-to-4 distributor.
// master drives the input word, select lines and per-channel acks;
// slave (the distributor) drives ready, the four held channels and status.
interface distributor14_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] iD;
    logic             iValid;
    logic             iS1;
    logic             iS0;
    logic             oReady;
    logic [3:0]       iAck;
    logic [WIDTH-1:0] oZ0;
    logic [WIDTH-1:0] oZ1;
    logic [WIDTH-1:0] oZ2;
    logic [WIDTH-1:0] oZ3;
    logic [3:0]       oV;
    logic [2:0]       oCnt;
    logic             oDrop;

    modport master (
        output iD, iValid, iS1, iS0, iAck,
        input  oReady, oZ0, oZ1, oZ2, oZ3, oV, oCnt, oDrop
    );

    modport slave (
        input  iD, iValid, iS1, iS0, iAck,
        output oReady, oZ0, oZ1, oZ2, oZ3, oV, oCnt, oDrop
    );
endinterface

// File: rtl/distributor14.sv
// distributor14: registered 1-to-4 demultiplexer / distributor.
// One word per cycle is steered into one of four holding channels; each
// channel keeps its word and a full flag until its consumer acks it.
// Optional build macro DISTRIBUTOR14_RR_EN: the target channel comes from an
// internal round-robin pointer instead of the iS1/iS0 select lines.
module distributor14 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    distributor14_if.slave   bus
);

    logic [3:0][WIDTH-1:0] z_q;
    logic [3:0]            v_q;
    logic [3:0]            v_next;
    logic [2:0]            cnt_q;
    logic [2:0]            cnt_next;
    logic                  drop_q;
    logic [1:0]            target;
    logic                  ready;
    logic                  accept;

`ifdef DISTRIBUTOR14_RR_EN
    logic [1:0] ptr_q;

    assign target = ptr_q;

    // Round-robin pointer: advances only on an accepted word, wraps 3 -> 0.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= ptr_q + 2'd1;
        end
    end
`else
    assign target = {bus.iS1, bus.iS0};
`endif

    // A full target channel can still take a word if it is being acked now.
    assign ready  = ~v_q[target] | bus.iAck[target];
    assign accept = bus.iValid & ready;

    // Next full flags (acks clear, accept sets, set wins) and their popcount.
    always_comb begin
        v_next = v_q & ~bus.iAck;
        if (accept) begin
            v_next[target] = 1'b1;
        end
        cnt_next = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            cnt_next = cnt_next + {2'b00, v_next[k]};
        end
    end

    // Channel data, full flags and count; acked data is held, not cleared.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            z_q   <= '0;
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_next;
            cnt_q <= cnt_next;
            if (accept) begin
                z_q[target] <= bus.iD;
            end
        end
    end

    // Sticky overflow flag: set when a valid word meets a busy channel.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            drop_q <= 1'b0;
        end else if (bus.iValid & ~ready) begin
            drop_q <= 1'b1;
        end
    end

    assign bus.oReady = ready;
    assign bus.oZ0    = z_q[0];
    assign bus.oZ1    = z_q[1];
    assign bus.oZ2    = z_q[2];
    assign bus.oZ3    = z_q[3];
    assign bus.oV     = v_q;
    assign bus.oCnt   = cnt_q;
    assign bus.oDrop  = drop_q;

endmodule

// File: tb/tb_distributor14.sv
// tb_distributor14: scoreboard bench for distributor14.
// The stimulus process drives one cycle at a time, pushes the expected
// ready/state into a queue and advances a behavioural channel model; the
// monitor pops and compares at each falling edge.
`timescale 1ns/1ps
module tb_distributor14;

    localparam int unsigned WIDTH = 4;
`ifdef DISTRIBUTOR14_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    distributor14_if #(.WIDTH(WIDTH)) bus ();

    distributor14 #(.WIDTH(WIDTH)) dut (
        .iClk  (clk),
        .iRst_n(rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic                  rdy;
        logic [3:0]            v;
        logic [2:0]            cnt;
        logic                  drop;
        logic [3:0][WIDTH-1:0] z;
    } exp_t;

    exp_t sb[$];

    // Behavioural model: four mailboxes with full flags.
    logic [WIDTH-1:0] md [4];
    bit               mv [4];
    bit               mdrop;
    int               mptr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            md[k] = '0;
            mv[k] = 1'b0;
        end
        mdrop = 1'b0;
        mptr  = 0;
    endtask

    // Drive one cycle of stimulus, record expectations, then step the model.
    task automatic drive_cycle(input logic [WIDTH-1:0] d, input logic valid,
                               input logic [1:0] s, input logic [3:0] ack);
        exp_t e;
        int   t;
        int   full;
        @(posedge clk);
        #1;
        bus.iD     = d;
        bus.iValid = valid;
        bus.iS1    = s[1];
        bus.iS0    = s[0];
        bus.iAck   = ack;
        t = RR ? mptr : int'(s);
        e.rdy = !mv[t] || ack[t];
        full = 0;
        for (int k = 0; k < 4; k++) begin
            e.v[k] = mv[k];
            e.z[k] = md[k];
            full += mv[k] ? 1 : 0;
        end
        e.cnt  = 3'(full);
        e.drop = mdrop;
        sb.push_back(e);
        for (int k = 0; k < 4; k++) begin
            if (ack[k]) mv[k] = 1'b0;
        end
        if (valid) begin
            if (e.rdy) begin
                md[t] = d;
                mv[t] = 1'b1;
                mptr  = (mptr + 1) % 4;
            end else begin
                mdrop = 1'b1;
            end
        end
    endtask

    task automatic idle();
        drive_cycle('0, 1'b0, 2'b00, 4'b0000);
    endtask

    // Asynchronous reset between edges; outputs must clear immediately.
    task automatic reset_mid();
        @(posedge clk);
        #1;
        bus.iValid = 1'b0;
        bus.iAck   = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_v",    32'(bus.oV),    32'h0);
        check("rst_cnt",  32'(bus.oCnt),  32'h0);
        check("rst_drop", 32'(bus.oDrop), 32'h0);
        check("rst_z0",   32'(bus.oZ0),   32'h0);
        check("rst_z1",   32'(bus.oZ1),   32'h0);
        check("rst_z2",   32'(bus.oZ2),   32'h0);
        check("rst_z3",   32'(bus.oZ3),   32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    initial begin
        exp_t             e;
        logic [WIDTH-1:0] zo [4];
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                zo[0] = bus.oZ0;
                zo[1] = bus.oZ1;
                zo[2] = bus.oZ2;
                zo[3] = bus.oZ3;
                check("ready", 32'(bus.oReady), 32'(e.rdy));
                check("v",     32'(bus.oV),     32'(e.v));
                check("cnt",   32'(bus.oCnt),   32'(e.cnt));
                check("drop",  32'(bus.oDrop),  32'(e.drop));
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("z%0d", k), 32'(zo[k]), 32'(e.z[k]));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n      = 1'b0;
        bus.iD     = '0;
        bus.iValid = 1'b0;
        bus.iS1    = 1'b0;
        bus.iS0    = 1'b0;
        bus.iAck   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        if (RR) begin
            // Fill 0..3 with 1..4, offer a word while channel 0 is full,
            // drain channel 0, then the next word lands in channel 0.
            for (int i = 1; i <= 4; i++) drive_cycle(WIDTH'(i), 1'b1, 2'b00, 4'b0000);
            drive_cycle(4'h6, 1'b1, 2'b00, 4'b0000);
            drive_cycle('0, 1'b0, 2'b00, 4'b0001);
            drive_cycle(4'h5, 1'b1, 2'b11, 4'b0000);
            idle();
            drive_cycle('0, 1'b0, 2'b00, 4'b1111);
        end else begin
            // Steer to channel 2.
            drive_cycle(4'hA, 1'b1, 2'b10, 4'b0000);
            idle();
            // Ack channel 2 (data held), then ack empty channel 0.
            drive_cycle('0, 1'b0, 2'b00, 4'b0100);
            drive_cycle('0, 1'b0, 2'b00, 4'b0001);
            idle();
            // Fill channel 1, offer into it while full, then ack it.
            drive_cycle(4'h7, 1'b1, 2'b01, 4'b0000);
            drive_cycle(4'h9, 1'b1, 2'b01, 4'b0000);
            drive_cycle('0, 1'b0, 2'b00, 4'b0010);
            idle();
            // Write and ack channel 3 in the same cycle.
            drive_cycle(4'h5, 1'b1, 2'b11, 4'b0000);
            drive_cycle(4'hC, 1'b1, 2'b11, 4'b1000);
            idle();
        end

        // Randomized traffic with moderate ack pressure so channels fill.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] ack;
            for (int k = 0; k < 4; k++) ack[k] = ($urandom_range(0, 3) == 0);
            drive_cycle(WIDTH'($urandom), ($urandom_range(0, 9) < 7),
                        2'($urandom), ack);
        end

        // Load all four channels, then reset between edges.
        drive_cycle('0, 1'b0, 2'b00, 4'b1111);
        for (int k = 0; k < 4; k++) drive_cycle(WIDTH'(k + 8), 1'b1, 2'(k), 4'b0000);
        idle();
        reset_mid();

        // Post-reset sanity and a short random tail.
        idle();
        for (int i = 0; i < 40; i++) begin
            drive_cycle(WIDTH'($urandom), ($urandom_range(0, 1) == 1),
                        2'($urandom), 4'($urandom));
        end
        idle();

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            check("sb_drain", 32'(sb.size()), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
